decode_execute_stage: RTL

// - ID/EX pipeline boundary: registers decoded control bundle, operands, immediate, PC values.
// - Hosts load-use hazard detection; generates fetch/decode stalls and a decode flush.
// - Inserts a bubble into EX on load-use stall or taken branch.
// - Fed by control decoder + register file in ID; drives ALU, forwarding unit, EX/MEM register.

---
 rtl/decode_execute_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/decode_execute_stage.sv
// ID/EX pipeline register with load-use hazard detection, fetch/decode stall and decode flush.
// Optional bubble counter enabled by defining ID_EX_PERF_CNT_EN.
module decode_execute_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteD,
  input  logic                  ALUSrcD,
  input  logic                  MemWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  BranchD,
  input  logic [2:0]            ALUControlD,
  input  logic [DATA_W-1:0]     RD1_D,
  input  logic [DATA_W-1:0]     RD2_D,
  input  logic [DATA_W-1:0]     Imm_Ext_D,
  input  logic [DATA_W-1:0]     PCD,
  input  logic [DATA_W-1:0]     PCPlus4D,
  input  logic [REG_ADDR_W-1:0] Rs1_D,
  input  logic [REG_ADDR_W-1:0] Rs2_D,
  input  logic [REG_ADDR_W-1:0] RD_D,
  input  logic                  PCSrcE,
  output logic                  RegWriteE,
  output logic                  ALUSrcE,
  output logic                  MemWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  BranchE,
  output logic [2:0]            ALUControlE,
  output logic [DATA_W-1:0]     RD1_E,
  output logic [DATA_W-1:0]     RD2_E,
  output logic [DATA_W-1:0]     Imm_Ext_E,
  output logic [DATA_W-1:0]     PCE,
  output logic [DATA_W-1:0]     PCPlus4E,
  output logic [REG_ADDR_W-1:0] Rs1_E,
  output logic [REG_ADDR_W-1:0] Rs2_E,
  output logic [REG_ADDR_W-1:0] RD_E,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic [CNT_W-1:0]      BubbleCnt
);

  logic                  regwrite_p1;
  logic                  alusrc_p1;
  logic                  memwrite_p1;
  logic [1:0]            resultsrc_p1;
  logic                  branch_p1;
  logic [2:0]            aluctl_p1;
  logic [REG_ADDR_W-1:0] rs1_p1;
  logic [REG_ADDR_W-1:0] rs2_p1;
  logic [REG_ADDR_W-1:0] rd_p1;
  logic [DATA_W-1:0]     rd1_p1;
  logic [DATA_W-1:0]     rd2_p1;
  logic [DATA_W-1:0]     imm_p1;
  logic [DATA_W-1:0]     pc_p1;
  logic [DATA_W-1:0]     pcplus4_p1;

  logic lw_stall;
  logic bubble;

  // A load in EX writing a non-zero register that ID is about to read.
  assign lw_stall = (resultsrc_p1 == 2'b01) & regwrite_p1 & (rd_p1 != '0) &
                    ((rd_p1 == Rs1_D) | (rd_p1 == Rs2_D));
  assign bubble   = lw_stall | PCSrcE;

  assign StallF = lw_stall;
  assign StallD = lw_stall;
  assign FlushD = PCSrcE;

  // ---- ID -> EX boundary: control fields, zeroed on a bubble ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_p1  <= 1'b0;
      alusrc_p1    <= 1'b0;
      memwrite_p1  <= 1'b0;
      resultsrc_p1 <= 2'b00;
      branch_p1    <= 1'b0;
      aluctl_p1    <= 3'b000;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rd_p1        <= '0;
    end else if (bubble) begin
      regwrite_p1  <= 1'b0;
      alusrc_p1    <= 1'b0;
      memwrite_p1  <= 1'b0;
      resultsrc_p1 <= 2'b00;
      branch_p1    <= 1'b0;
      aluctl_p1    <= 3'b000;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rd_p1        <= '0;
    end else begin
      regwrite_p1  <= RegWriteD;
      alusrc_p1    <= ALUSrcD;
      memwrite_p1  <= MemWriteD;
      resultsrc_p1 <= ResultSrcD;
      branch_p1    <= BranchD;
      aluctl_p1    <= ALUControlD;
      rs1_p1       <= Rs1_D;
      rs2_p1       <= Rs2_D;
      rd_p1        <= RD_D;
    end
  end

  // Data fields always load; a bubble's zeroed controls make their contents irrelevant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd1_p1     <= '0;
      rd2_p1     <= '0;
      imm_p1     <= '0;
      pc_p1      <= '0;
      pcplus4_p1 <= '0;
    end else begin
      rd1_p1     <= RD1_D;
      rd2_p1     <= RD2_D;
      imm_p1     <= Imm_Ext_D;
      pc_p1      <= PCD;
      pcplus4_p1 <= PCPlus4D;
    end
  end

  assign RegWriteE   = regwrite_p1;
  assign ALUSrcE     = alusrc_p1;
  assign MemWriteE   = memwrite_p1;
  assign ResultSrcE  = resultsrc_p1;
  assign BranchE     = branch_p1;
  assign ALUControlE = aluctl_p1;
  assign Rs1_E       = rs1_p1;
  assign Rs2_E       = rs2_p1;
  assign RD_E        = rd_p1;
  assign RD1_E       = rd1_p1;
  assign RD2_E       = rd2_p1;
  assign Imm_Ext_E   = imm_p1;
  assign PCE         = pc_p1;
  assign PCPlus4E    = pcplus4_p1;

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bubble_cnt_p1 <= '0;
    else if (bubble)
      bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
  end

  assign BubbleCnt = bubble_cnt_p1;
`else
  assign BubbleCnt = '0;
`endif

endmodule
